// File: rtl/rc4_mem_pkg.sv
// rc4_mem_pkg
//   Shared definitions for the RC4 message memory blocks (ROM loader,
//   decrypt core and RAM writer).
//   - MSG_LEN / MSG_ADDR_W : message length in bytes and its address width
//   - msg_t                : the message held as an unpacked byte array
//   - wr_state_t           : FSM states of write_ram_mem
package rc4_mem_pkg;

  localparam int MSG_LEN    = 32;
  localparam int MSG_ADDR_W = 5;

  typedef logic [7:0] msg_t [MSG_LEN];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RADDR,
    ST_RWAIT,
    ST_RCMP,
    ST_DONE
  } wr_state_t;

endpackage

// File: rtl/write_ram_mem.sv
// write_ram_mem
//   Commits a MSG_BYTES-byte message into an on-chip RAM, one byte per
//   cycle, then optionally reads every location back and flags the first
//   location whose contents differ from the message.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   synchronous active-low reset
//   start       in   level start request, honoured in IDLE and DONE only
//   data_in     in   message bytes; data_in[k] goes to address k
//   ram_address out  RAM address
//   ram_data    out  RAM write data
//   ram_wren    out  RAM write enable
//   ram_q       in   RAM read data, valid RD_LAT cycles after the address
//   busy        out  run in progress
//   done        out  run finished (level, held until restart or reset)
//   verify_err  out  a read-back mismatch was seen in this run
//   err_index   out  address of the first mismatch
module write_ram_mem
  import rc4_mem_pkg::*;
#(
  parameter int MSG_BYTES = MSG_LEN,
  parameter int ADDR_W    = MSG_ADDR_W,
  parameter int VERIFY    = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        data_in [MSG_BYTES],
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [ADDR_W-1:0] err_index
);

  // One extra bit so the index cannot wrap when MSG_BYTES == 2**ADDR_W.
  localparam int               IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [1:0]       WAIT_END = 2'(RD_LAT - 2);

  wr_state_t         state;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        wait_cnt;
  logic [7:0]        msg_buf [MSG_BYTES];
  logic [ADDR_W-1:0] addr;
  logic              accept;

  assign addr   = idx[ADDR_W-1:0];
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // RAM-side outputs decode straight from registers, so they are stable
  // for the whole cycle.
  assign ram_address = addr;
  assign ram_wren    = (state == ST_WRITE);
  assign ram_data    = ram_wren ? msg_buf[addr] : 8'h00;

  // Private copy of the message so data_in may change during a run.
  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      for (int k = 0; k < MSG_BYTES; k++) begin
        msg_buf[k] <= data_in[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      verify_err <= 1'b0;
      err_index  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_WRITE;
            idx        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            verify_err <= 1'b0;
            err_index  <= '0;
          end
        end

        ST_WRITE: begin
          if (idx == LAST_IDX) begin
            if (VERIFY != 0) begin
              state <= ST_RADDR;
              idx   <= '0;
            end else begin
              state <= ST_DONE;
              idx   <= idx + 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ST_RADDR: begin
          wait_cnt <= '0;
          state    <= (RD_LAT == 1) ? ST_RCMP : ST_RWAIT;
        end

        // Spends RD_LAT-1 cycles here so ram_q is valid in RCMP.
        ST_RWAIT: begin
          if (wait_cnt == WAIT_END) begin
            state <= ST_RCMP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        // Only the first mismatch of a run is recorded.
        ST_RCMP: begin
          if ((ram_q != msg_buf[addr]) && !verify_err) begin
            verify_err <= 1'b1;
            err_index  <= addr;
          end
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_RADDR;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_ram_mem.sv
// tb_write_ram_mem
//   Directed bench for write_ram_mem. The main instance uses VERIFY=1,
//   RD_LAT=1; two extra instances cover VERIFY=0/RD_LAT=3 and
//   VERIFY=1/RD_LAT=3. Each instance has its own behavioural RAM.
module tb_write_ram_mem;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in [32];

  always #5 clk = ~clk;

  // Main instance (VERIFY=1, RD_LAT=1)
  logic [4:0] addr_a, err_a;
  logic [7:0] wdata_a, q_a;
  logic       wren_a, busy_a, done_a, verr_a;
  logic       corrupt = 1'b0;
  logic [7:0] mem_a [32];

  write_ram_mem #(.MSG_BYTES(32), .ADDR_W(5), .VERIFY(1), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .ram_address(addr_a), .ram_data(wdata_a), .ram_wren(wren_a), .ram_q(q_a),
    .busy(busy_a), .done(done_a), .verify_err(verr_a), .err_index(err_a)
  );

  // 1-cycle RAM; optional corruption of locations 5 and 9 on read
  always @(posedge clk) begin
    if (wren_a) mem_a[addr_a] <= wdata_a;
    if (corrupt && addr_a == 5'd5)      q_a <= 8'hFF;
    else if (corrupt && addr_a == 5'd9) q_a <= 8'h00;
    else                                q_a <= mem_a[addr_a];
  end

  // VERIFY=0, RD_LAT=3 instance
  logic [4:0] addr_n, err_n;
  logic [7:0] wdata_n, q_n, pn1, pn2;
  logic       wren_n, busy_n, done_n, verr_n;
  logic [7:0] mem_n [32];

  write_ram_mem #(.MSG_BYTES(32), .ADDR_W(5), .VERIFY(0), .RD_LAT(3)) dut_nv (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .ram_address(addr_n), .ram_data(wdata_n), .ram_wren(wren_n), .ram_q(q_n),
    .busy(busy_n), .done(done_n), .verify_err(verr_n), .err_index(err_n)
  );

  always @(posedge clk) begin
    if (wren_n) mem_n[addr_n] <= wdata_n;
    pn1 <= mem_n[addr_n];
    pn2 <= pn1;
    q_n <= pn2;
  end

  // VERIFY=1, RD_LAT=3 instance
  logic [4:0] addr_l, err_l;
  logic [7:0] wdata_l, q_l, pl1, pl2;
  logic       wren_l, busy_l, done_l, verr_l;
  logic [7:0] mem_l [32];

  write_ram_mem #(.MSG_BYTES(32), .ADDR_W(5), .VERIFY(1), .RD_LAT(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
    .ram_address(addr_l), .ram_data(wdata_l), .ram_wren(wren_l), .ram_q(q_l),
    .busy(busy_l), .done(done_l), .verify_err(verr_l), .err_index(err_l)
  );

  always @(posedge clk) begin
    if (wren_l) mem_l[addr_l] <= wdata_l;
    pl1 <= mem_l[addr_l];
    pl2 <= pl1;
    q_l <= pl2;
  end

  int         total = 0;
  int         fails = 0;
  int         cyc = 0;
  int         e0 = 0;
  int         wr_count = 0;
  int         overlap = 0;
  logic [7:0] exp_data [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor on the main instance: every write must land at the next
  // ascending address with the byte captured at start.
  always @(negedge clk) begin
    if (wren_a === 1'b1) begin
      if (wr_count < 32) begin
        checkOutput("wr_addr", 32'(addr_a), 32'(wr_count));
        checkOutput("wr_data", 32'(wdata_a), 32'(exp_data[wr_count]));
      end else begin
        checkOutput("wr_overflow", 32'(wr_count), 32'd31);
      end
      wr_count <= wr_count + 1;
    end
    if (busy_a === 1'b1 && done_a === 1'b1) overlap <= overlap + 1;
  end

  // Loads the message, raises start for one edge (E0) and returns at the
  // falling edge after E0 with e0 marking that edge.
  task automatic applyStimulus(input bit desc);
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      data_in[k]  = desc ? 8'(8'hFF - k) : 8'(k);
      exp_data[k] = data_in[k];
    end
    wr_count = 0;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e0    = cyc;
  endtask

  // Returns the number of edges from E0 to the edge that raised done,
  // or -1 if done never rose within the limit.
  task automatic waitDone(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit && n < 0; i++) begin
      if (done_a === 1'b1) n = cyc - e0;
      else @(negedge clk);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},  32'(busy_a),  32'd0);
    checkOutput({tag, "_done"},  32'(done_a),  32'd0);
    checkOutput({tag, "_verr"},  32'(verr_a),  32'd0);
    checkOutput({tag, "_eidx"},  32'(err_a),   32'd0);
    checkOutput({tag, "_wren"},  32'(wren_a),  32'd0);
    checkOutput({tag, "_addr"},  32'(addr_a),  32'd0);
    checkOutput({tag, "_wdata"}, 32'(wdata_a), 32'd0);
  endtask

  int n, t_nv, t_l3;

  initial begin
    for (int k = 0; k < 32; k++) begin
      data_in[k]  = 8'(k);
      exp_data[k] = 8'(k);
    end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    reset_n = 1'b1;

    // Basic write with verify
    $display("[TB] basic write + verify");
    applyStimulus(1'b0);
    checkOutput("basic_busy", 32'(busy_a), 32'd1);
    checkOutput("basic_done0", 32'(done_a), 32'd0);
    waitDone(200, n);
    checkOutput("basic_done_time", 32'(n), 32'd96);
    checkOutput("basic_writes", 32'(wr_count), 32'd32);
    checkOutput("basic_verr", 32'(verr_a), 32'd0);
    checkOutput("basic_busy_end", 32'(busy_a), 32'd0);

    // Corrupted RAM read-back, restarted from DONE
    $display("[TB] corrupted read-back");
    corrupt = 1'b1;
    applyStimulus(1'b0);
    checkOutput("corr_done_drop", 32'(done_a), 32'd0);
    waitDone(200, n);
    checkOutput("corr_done_time", 32'(n), 32'd96);
    checkOutput("corr_verr", 32'(verr_a), 32'd1);
    checkOutput("corr_eidx", 32'(err_a), 32'd5);
    corrupt = 1'b0;

    // Snapshot isolation and start while busy
    $display("[TB] snapshot + start while busy");
    applyStimulus(1'b0);
    for (int k = 0; k < 32; k++) data_in[k] = 8'hA5;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(200, n);
    checkOutput("snap_done_time", 32'(n), 32'd96);
    checkOutput("snap_writes", 32'(wr_count), 32'd32);
    checkOutput("snap_verr", 32'(verr_a), 32'd0);

    // Reset in the middle of WRITE
    $display("[TB] reset mid-run");
    applyStimulus(1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkResetState("midrst");
    checkOutput("midrst_writes", 32'(wr_count), 32'd10);
    reset_n = 1'b1;
    applyStimulus(1'b0);
    waitDone(200, n);
    checkOutput("midrst_rerun_time", 32'(n), 32'd96);
    checkOutput("midrst_rerun_writes", 32'(wr_count), 32'd32);
    checkOutput("midrst_rerun_verr", 32'(verr_a), 32'd0);

    // Restart from DONE with a descending pattern
    $display("[TB] restart from DONE");
    checkOutput("restart_pre_done", 32'(done_a), 32'd1);
    applyStimulus(1'b1);
    checkOutput("restart_done_drop", 32'(done_a), 32'd0);
    waitDone(200, n);
    checkOutput("restart_done_time", 32'(n), 32'd96);
    checkOutput("restart_writes", 32'(wr_count), 32'd32);
    checkOutput("restart_verr", 32'(verr_a), 32'd0);

    // Read latency 3, with and without verify
    $display("[TB] RD_LAT=3 variants");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0);
    t_nv = -1;
    t_l3 = -1;
    for (int i = 0; i < 400 && (t_nv < 0 || t_l3 < 0); i++) begin
      if (done_n === 1'b1 && t_nv < 0) t_nv = cyc - e0;
      if (done_l === 1'b1 && t_l3 < 0) t_l3 = cyc - e0;
      @(negedge clk);
    end
    checkOutput("nv_done_time", 32'(t_nv), 32'd32);
    checkOutput("nv_verr", 32'(verr_n), 32'd0);
    checkOutput("l3_done_time", 32'(t_l3), 32'd160);
    checkOutput("l3_verr", 32'(verr_l), 32'd0);
    checkOutput("l3_eidx", 32'(err_l), 32'd0);

    checkOutput("busy_done_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/write_ram_mem.md
# write_ram_mem

Writes a 32-byte message held in a register array into the 32×8 on-chip RAM, one byte per cycle. An optional read-back pass checks every location and reports the first mismatch. It is the write-side counterpart of the ROM-to-register loader. It sits after the RC4 decrypt datapath and commits the decrypted message to the output RAM for the key search to inspect.

## Interface
Parameters:
- MSG_BYTES, 32, number of bytes written; also the RAM depth
- ADDR_W, 5, RAM address width; must satisfy 2^ADDR_W ≥ MSG_BYTES
- VERIFY, 1, 1 enables the read-back pass; 0 skips it
- RD_LAT, 1, RAM read latency in cycles from address presented to `ram_q` valid; 1..3

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  level; sampled in IDLE and DONE only
- data_in  in  8 × MSG_BYTES  unpacked byte array; `data_in[k]` goes to address k
- ram_address  out  ADDR_W  RAM address
- ram_data  out  8  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  8  RAM read data
- busy  out  1  high from the start acceptance until done
- done  out  1  high in DONE; stays high until restart or reset
- verify_err  out  1  a read-back mismatch was seen in this run
- err_index  out  ADDR_W  address of the first mismatch; valid when `verify_err` is high

## Operation
- States: IDLE, WRITE, RADDR, RWAIT, RCMP, DONE.
- IDLE → WRITE when `start` = 1.
  - On that edge, snapshot all of `data_in` into an internal buffer.
  - idx ← 0, busy ← 1, done ← 0, verify_err ← 0, err_index ← 0.
- WRITE:
  - ram_wren = 1, ram_address = idx, ram_data = buf[idx].
  - Each edge: idx ← idx + 1.
  - When idx = MSG_BYTES−1: go to RADDR with idx ← 0 if VERIFY = 1, otherwise go to DONE.
- RADDR: ram_wren = 0, ram_address = idx. Go to RWAIT, or to RCMP directly if RD_LAT = 1.
- RWAIT: hold ram_address for RD_LAT−1 cycles, counted by a wait counter, then go to RCMP.
- RCMP:
  - Compare `ram_q` to buf[idx].
  - On a mismatch with verify_err = 0: verify_err ← 1, err_index ← idx. Later mismatches are ignored.
  - If idx = MSG_BYTES−1, go to DONE; otherwise idx ← idx + 1 and go to RADDR.
- DONE: done = 1, busy = 0. If `start` = 1, take the IDLE→WRITE action: new snapshot, done ← 0.
- `start` in any other state is ignored.
- Changes to `data_in` after the snapshot have no effect on the run.
- idx is ADDR_W+1 bits wide, so it never wraps at MSG_BYTES = 2^ADDR_W. `ram_address` = idx[ADDR_W-1:0].

## Timing
- Reset (reset_n = 0 at an edge) drives:
  - state IDLE, idx 0
  - busy 0, done 0, verify_err 0, err_index 0
  - ram_wren 0, ram_address 0, ram_data 0
- Reset mid-run aborts at once. `ram_wren` is low in the cycle after the reset edge. RAM contents are left partial. No done pulse is produced.
- `ram_wren`, `ram_address` and `ram_data` decode from registered state and idx. They are glitch-free and stable for the whole cycle.
- Let E0 be the edge that accepts `start`:
  - Writes occupy cycles E0..E32 exactly, one byte per cycle, addresses 0..31 ascending.
  - VERIFY = 0: done rises at E32.
  - VERIFY = 1: each byte takes RD_LAT+1 cycles, so done rises at E32 + MSG_BYTES·(RD_LAT+1). With RD_LAT = 1 this is E96.
- `done` and `busy` are never high together. `done` is level, not a pulse.

## Structure
- Shared package `rc4_mem_pkg` holds:
  - MSG_BYTES (32) and the message address width
  - the state enum type for this block
  - the `msg_t` byte-array typedef, shared with the ROM loader and the decrypt core
- Single module. The byte counter, wait counter and FSM are small enough to stay inline; no sub-module.

## Test plan
- Basic write with verify: data_in[k] = k, VERIFY = 1, RD_LAT = 1, behavioural 1-cycle RAM. Expect ram_wren high for exactly 32 cycles at addresses 0..31 with data 0x00..0x1F, done at E96, verify_err = 0.
- Corrupted RAM: the model returns 0xFF at address 5 and 0x00 at address 9. Expect verify_err = 1, err_index = 5 (first mismatch wins), done still at E96.
- Snapshot and start-while-busy: after E0, change data_in to all 0xA5 and pulse start at cycle 10. Expect the original 0x00..0x1F written, no restart, and the same done time.
- Reset mid-run: reset_n low at cycle 10 of WRITE. Expect ram_wren = 0 and all outputs at their reset values after that edge. A following start completes a full run.
- Restart from DONE: start with data_in[k] = 0xFF−k while done = 1. Expect done to drop at the next edge, 32 new writes 0xFF..0xE0, then done again.
- VERIFY = 0 with RD_LAT = 3: expect no read states and done at E32. With VERIFY = 1 and RD_LAT = 3, expect done at E32 + 128.
